// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP divider special-operand front end:
// class bit indices and canonical special-value builders.
package fp_div_pkg;

    localparam int CLS_W    = 6;
    localparam int CLS_ZERO = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_NORM = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_QNAN = 4;
    localparam int CLS_SNAN = 5;

    typedef logic [CLS_W-1:0] cls_t;

    // Builders return a 64-bit word; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] fp_inf(input logic s, input int exp_w,
                                           input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r[exp_w+man_w] = s;
        return r;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = fp_inf(1'b0, exp_w, man_w) | (64'd1 << (man_w - 1));
        return r;
    endfunction

    function automatic logic [63:0] fp_zero(input logic s, input int exp_w,
                                            input int man_w);
        logic [63:0] r;
        r = '0;
        r[exp_w+man_w] = s;
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// One-hot operand classifier (sign excluded); FTZ folds subnormals
// into the zero class.
module fp_classify
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 0
) (
    input  logic [EXP_W+MAN_W-1:0] op_i,
    output cls_t                   cls_o
);

    localparam bit FTZ_B = (FTZ != 0);

    logic [EXP_W-1:0] exp_w;
    logic [MAN_W-1:0] frac_w;
    logic             exp_zero;
    logic             exp_ones;
    logic             frac_nz;

    assign exp_w    = op_i[MAN_W +: EXP_W];
    assign frac_w   = op_i[MAN_W-1:0];
    assign exp_zero = ~|exp_w;
    assign exp_ones = &exp_w;
    assign frac_nz  = |frac_w;

    always_comb begin
        cls_o           = '0;
        cls_o[CLS_ZERO] = exp_zero & (~frac_nz | FTZ_B);
        cls_o[CLS_SUB]  = exp_zero & frac_nz & ~FTZ_B;
        cls_o[CLS_NORM] = ~exp_zero & ~exp_ones;
        cls_o[CLS_INF]  = exp_ones & ~frac_nz;
        cls_o[CLS_QNAN] = exp_ones & frac_w[MAN_W-1];
        cls_o[CLS_SNAN] = exp_ones & ~frac_w[MAN_W-1] & frac_nz;
    end

endmodule

// File: rtl/fp_div_special_pipe.sv
// Two-stage special-operand resolver in front of the mantissa divider:
// S1 classifies, S2 holds the resolved quotient and bypass decision.
module fp_div_special_pipe
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 0,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output cls_t         out_cls_a,
    output cls_t         out_cls_b,
    output logic         out_bypass,
    output logic [W-1:0] out_result,
    input  logic         flag_clr,
    output logic         flag_invalid,
    output logic         flag_divzero
);

    localparam logic [63:0]  QN_F  = fp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]  INF_F = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [63:0]  ZER_F = fp_zero(1'b0, EXP_W, MAN_W);
    localparam logic [W-1:0] QN    = QN_F[W-1:0];
    localparam logic [W-1:0] INF_P = INF_F[W-1:0];
    localparam logic [W-1:0] ZER_P = ZER_F[W-1:0];

    cls_t ca_c;
    cls_t cb_c;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_a (
        .op_i  (in_a[W-2:0]),
        .cls_o (ca_c)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_b (
        .op_i  (in_b[W-2:0]),
        .cls_o (cb_c)
    );

    logic         s1_v_q;
    logic         s1_sa_q;
    logic         s1_sb_q;
    cls_t         s1_ca_q;
    cls_t         s1_cb_q;

    logic         s2_v_q;
    cls_t         s2_ca_q;
    cls_t         s2_cb_q;
    logic         s2_byp_q;
    logic [W-1:0] s2_res_q;
    logic         s2_inv_q;
    logic         s2_dz_q;

    logic         flag_inv_q;
    logic         flag_dz_q;

    logic         s1_adv;
    logic         s2_adv;
    logic         out_hs;

    assign s2_adv   = ~s2_v_q | out_ready;
    assign s1_adv   = ~s1_v_q | s2_adv;
    assign in_ready = s1_adv & ~rst;
    assign out_hs   = s2_v_q & out_ready;

    logic         sgn;
    logic         a_z, a_inf, a_qn, a_sn;
    logic         b_z, b_inf, b_qn, b_sn;
    logic         byp_d;
    logic [W-1:0] res_d;
    logic         inv_d;
    logic         dz_d;

    assign sgn   = s1_sa_q ^ s1_sb_q;
    assign a_z   = s1_ca_q[CLS_ZERO];
    assign a_inf = s1_ca_q[CLS_INF];
    assign a_qn  = s1_ca_q[CLS_QNAN];
    assign a_sn  = s1_ca_q[CLS_SNAN];
    assign b_z   = s1_cb_q[CLS_ZERO];
    assign b_inf = s1_cb_q[CLS_INF];
    assign b_qn  = s1_cb_q[CLS_QNAN];
    assign b_sn  = s1_cb_q[CLS_SNAN];

    // Earlier arms have already excluded NaN/inf, so later arms may
    // assume the remaining operand is finite.
    always_comb begin
        byp_d = 1'b0;
        res_d = '0;
        inv_d = 1'b0;
        dz_d  = 1'b0;
        priority case (1'b1)
            a_sn | b_sn: begin
                byp_d = 1'b1;
                res_d = QN;
                inv_d = 1'b1;
            end
            a_qn | b_qn: begin
                byp_d = 1'b1;
                res_d = QN;
            end
            (a_inf & b_inf) | (a_z & b_z): begin
                byp_d = 1'b1;
                res_d = QN;
                inv_d = 1'b1;
            end
            a_inf: begin
                byp_d = 1'b1;
                res_d = {sgn, INF_P[W-2:0]};
            end
            b_z: begin
                byp_d = 1'b1;
                res_d = {sgn, INF_P[W-2:0]};
                dz_d  = 1'b1;
            end
            b_inf | a_z: begin
                byp_d = 1'b1;
                res_d = {sgn, ZER_P[W-2:0]};
            end
            default: begin
                byp_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
            s1_ca_q    <= '0;
            s1_cb_q    <= '0;
            s2_v_q     <= 1'b0;
            s2_ca_q    <= '0;
            s2_cb_q    <= '0;
            s2_byp_q   <= 1'b0;
            s2_res_q   <= '0;
            s2_inv_q   <= 1'b0;
            s2_dz_q    <= 1'b0;
            flag_inv_q <= 1'b0;
            flag_dz_q  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_q  <= in_valid;
                s1_sa_q <= in_a[W-1];
                s1_sb_q <= in_b[W-1];
                s1_ca_q <= ca_c;
                s1_cb_q <= cb_c;
            end
            if (s2_adv) begin
                s2_v_q   <= s1_v_q;
                s2_ca_q  <= s1_ca_q;
                s2_cb_q  <= s1_cb_q;
                s2_byp_q <= byp_d;
                s2_res_q <= res_d;
                s2_inv_q <= inv_d;
                s2_dz_q  <= dz_d;
            end
            // A same-cycle event wins over a clear.
            flag_inv_q <= (flag_inv_q & ~flag_clr) | (out_hs & s2_inv_q);
            flag_dz_q  <= (flag_dz_q & ~flag_clr) | (out_hs & s2_dz_q);
        end
    end

    assign out_valid    = s2_v_q;
    assign out_cls_a    = s2_ca_q;
    assign out_cls_b    = s2_cb_q;
    assign out_bypass   = s2_byp_q;
    assign out_result   = s2_res_q;
    assign flag_invalid = flag_inv_q;
    assign flag_divzero = flag_dz_q;

endmodule
